// File: rtl/qkv_loader_if.sv
// Row-stream input and matrix/control output bundle of the QKV loader.
interface qkv_loader_if #(
   parameter int unsigned D_W = 16,
   parameter int unsigned DIM = 64,
   parameter int unsigned D_K = 64
);
   localparam int unsigned ROW_W = D_K * D_W;
   localparam int unsigned MAT_W = DIM * ROW_W;

   logic             I_ROW_VLD;
   logic             O_ROW_RDY;
   logic [ROW_W-1:0] I_ROW_DATA;
   logic             I_ATT_VLD;
   logic             O_START;
   logic [MAT_W-1:0] O_MAT_Q;
   logic [MAT_W-1:0] O_MAT_K;
   logic [MAT_W-1:0] O_MAT_V;
   logic             O_BUSY;
   logic             O_DONE;

   // Stream source / core side.
   modport master (
      output I_ROW_VLD, I_ROW_DATA, I_ATT_VLD,
      input  O_ROW_RDY, O_START, O_MAT_Q, O_MAT_K, O_MAT_V, O_BUSY, O_DONE
   );

   // Loader side.
   modport slave (
      input  I_ROW_VLD, I_ROW_DATA, I_ATT_VLD,
      output O_ROW_RDY, O_START, O_MAT_Q, O_MAT_K, O_MAT_V, O_BUSY, O_DONE
   );
endinterface

// File: rtl/qkv_loader.sv
// Assembles row-serial Q, K, V into flat matrices, starts the attention
// core, then holds the matrices and blocks input until the result returns.
module qkv_loader #(
   parameter int unsigned D_W = 16,
   parameter int unsigned DIM = 64,
   parameter int unsigned D_K = 64
) (
   input  logic        I_CLK,
   input  logic        I_RST,
   qkv_loader_if.slave bus
);
   localparam int unsigned ROW_W = D_K * D_W;
   localparam int unsigned MAT_W = DIM * ROW_W;
   localparam int unsigned CNT_W = (DIM > 1) ? $clog2(DIM) : 1;

   typedef enum logic [1:0] {ST_LOAD, ST_START, ST_WAIT} state_e;
   typedef enum logic [1:0] {SEL_Q, SEL_K, SEL_V} sel_e;

   state_e           state_q, state_d;
   sel_e             sel_q, sel_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [MAT_W-1:0] q_mat_q, q_mat_d;
   logic [MAT_W-1:0] k_mat_q, k_mat_d;
   logic [MAT_W-1:0] v_mat_q, v_mat_d;
   logic             rdy_q, rdy_d;
   logic             start_q, start_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             fire;
   logic [31:0]      row_base;

   // Next state, row write and registered-output decode.
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      cnt_d    = cnt_q;
      q_mat_d  = q_mat_q;
      k_mat_d  = k_mat_q;
      v_mat_d  = v_mat_q;
      done_d   = 1'b0;
      fire     = bus.I_ROW_VLD && rdy_q;
      row_base = 32'(cnt_q) * 32'(ROW_W);

      unique case (state_q)
         ST_LOAD: begin
            if (fire) begin
               unique case (sel_q)
                  SEL_Q:   q_mat_d[row_base +: ROW_W] = bus.I_ROW_DATA;
                  SEL_K:   k_mat_d[row_base +: ROW_W] = bus.I_ROW_DATA;
                  SEL_V:   v_mat_d[row_base +: ROW_W] = bus.I_ROW_DATA;
                  default: ;
               endcase
               if (cnt_q == CNT_W'(DIM - 1)) begin
                  cnt_d = '0;
                  unique case (sel_q)
                     SEL_Q:   sel_d = SEL_K;
                     SEL_K:   sel_d = SEL_V;
                     default: begin
                        sel_d   = SEL_Q;
                        state_d = ST_START;
                     end
                  endcase
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_START: state_d = ST_WAIT;
         ST_WAIT: begin
            if (bus.I_ATT_VLD) begin
               state_d = ST_LOAD;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_LOAD;
      endcase

      // Outputs follow the state being entered so they line up with it.
      rdy_d   = (state_d == ST_LOAD);
      start_d = (state_d == ST_START);
      busy_d  = (state_d != ST_LOAD);
   end

   // State, matrix and output registers; reset discards any partial set.
   always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) begin
         state_q <= ST_LOAD;
         sel_q   <= SEL_Q;
         cnt_q   <= '0;
         q_mat_q <= '0;
         k_mat_q <= '0;
         v_mat_q <= '0;
         rdy_q   <= 1'b0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         q_mat_q <= q_mat_d;
         k_mat_q <= k_mat_d;
         v_mat_q <= v_mat_d;
         rdy_q   <= rdy_d;
         start_q <= start_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.O_ROW_RDY = rdy_q;
   assign bus.O_START   = start_q;
   assign bus.O_BUSY    = busy_q;
   assign bus.O_DONE    = done_q;
   assign bus.O_MAT_Q   = q_mat_q;
   assign bus.O_MAT_K   = k_mat_q;
   assign bus.O_MAT_V   = v_mat_q;
endmodule

// File: tb/tb_qkv_loader.sv
// Directed bench for qkv_loader with a transaction-level reference model.
module tb_qkv_loader;
   localparam int unsigned D_W   = 16;
   localparam int unsigned DIM   = 4;
   localparam int unsigned D_K   = 4;
   localparam int unsigned ROW_W = D_K * D_W;
   localparam int unsigned MAT_W = DIM * ROW_W;
   localparam int unsigned BEATS = 3 * DIM;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   t_done;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   qkv_loader_if #(.D_W(D_W), .DIM(DIM), .D_K(D_K)) bus ();
   qkv_loader #(.D_W(D_W), .DIM(DIM), .D_K(D_K)) dut (
      .I_CLK(clk),
      .I_RST(rst),
      .bus  (bus)
   );

   // Reference model: set-level view (beat index, phase), element arrays.
   logic [D_W-1:0] m_mat [3][DIM][D_K];
   logic m_rdy, m_start, m_busy, m_done;
   int   m_phase, m_beat;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int m = 0; m < 3; m++)
            for (int r = 0; r < DIM; r++)
               for (int c = 0; c < D_K; c++) m_mat[m][r][c] <= '0;
         m_phase <= 0; m_beat <= 0;
         m_rdy <= 1'b0; m_start <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0;
      end else begin
         m_start <= 1'b0;
         m_done  <= 1'b0;
         case (m_phase)
            0: begin
               m_rdy  <= 1'b1;
               m_busy <= 1'b0;
               if (bus.I_ROW_VLD && m_rdy) begin
                  for (int c = 0; c < D_K; c++)
                     m_mat[m_beat / DIM][m_beat % DIM][c] <= bus.I_ROW_DATA[c*D_W +: D_W];
                  if (m_beat == BEATS - 1) begin
                     m_beat <= 0; m_phase <= 1;
                     m_rdy <= 1'b0; m_start <= 1'b1; m_busy <= 1'b1;
                  end else begin
                     m_beat <= m_beat + 1;
                  end
               end
            end
            1: begin
               m_phase <= 2;
            end
            default: begin
               if (bus.I_ATT_VLD) begin
                  m_phase <= 0; m_done <= 1'b1; m_busy <= 1'b0; m_rdy <= 1'b1;
               end
            end
         endcase
      end
   end

   function automatic logic [MAT_W-1:0] m_flat(input int m);
      logic [MAT_W-1:0] f;
      f = '0;
      for (int r = 0; r < DIM; r++)
         for (int c = 0; c < D_K; c++) f[(r*D_K + c)*D_W +: D_W] = m_mat[m][r][c];
      return f;
   endfunction

   // Hand formula for a whole matrix: element (m,r,c) = base + m*256 + r*16 + c.
   function automatic logic [MAT_W-1:0] pat(input int base, input int m);
      logic [MAT_W-1:0] p;
      p = '0;
      for (int r = 0; r < DIM; r++)
         for (int c = 0; c < D_K; c++)
            p[(r*D_K + c)*D_W +: D_W] = D_W'(base + m*256 + r*16 + c);
      return p;
   endfunction

   function automatic logic [ROW_W-1:0] mk_row(input int base, input int m, input int r);
      logic [ROW_W-1:0] w;
      for (int c = 0; c < D_K; c++) w[c*D_W +: D_W] = D_W'(base + m*256 + r*16 + c);
      return w;
   endfunction

   task automatic check(input string name, input logic [MAT_W-1:0] act,
                        input logic [MAT_W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Per-cycle comparison against the model, sampled after the edge.
   always @(posedge clk) begin
      #2;
      check("cyc_rdy",   MAT_W'(bus.O_ROW_RDY), MAT_W'(m_rdy));
      check("cyc_start", MAT_W'(bus.O_START),   MAT_W'(m_start));
      check("cyc_busy",  MAT_W'(bus.O_BUSY),    MAT_W'(m_busy));
      check("cyc_done",  MAT_W'(bus.O_DONE),    MAT_W'(m_done));
      check("cyc_mat_q", bus.O_MAT_Q, m_flat(0));
      check("cyc_mat_k", bus.O_MAT_K, m_flat(1));
      check("cyc_mat_v", bus.O_MAT_V, m_flat(2));
   end

   task automatic send_beat(input int base, input int b);
      int guard;
      @(negedge clk);
      bus.I_ROW_VLD  = 1'b1;
      bus.I_ROW_DATA = mk_row(base, b / DIM, b % DIM);
      guard = 0;
      while (!bus.O_ROW_RDY && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20) begin
         total++; bad++;
         $display("FAIL rdy_timeout: ready never rose for beat %0d", b);
      end
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.I_ROW_VLD  = 1'b0;
         bus.I_ROW_DATA = {$urandom, $urandom};
      end
   endtask

   // Leave the START cycle, wait a few cycles, return the result, check DONE.
   task automatic finish_set(input int wait_cycles);
      repeat (wait_cycles) @(negedge clk);
      bus.I_ATT_VLD = 1'b1;
      @(negedge clk);
      bus.I_ATT_VLD = 1'b0;
      check("done_pulse", MAT_W'(bus.O_DONE), MAT_W'(1'b1));
      check("done_busy",  MAT_W'(bus.O_BUSY), MAT_W'(1'b0));
      check("done_rdy",   MAT_W'(bus.O_ROW_RDY), MAT_W'(1'b1));
      @(negedge clk);
      check("done_single", MAT_W'(bus.O_DONE), MAT_W'(1'b0));
   endtask

   task automatic check_start_cycle(input string tag);
      @(negedge clk);
      bus.I_ROW_VLD = 1'b0;
      check({tag, "_start"}, MAT_W'(bus.O_START),   MAT_W'(1'b1));
      check({tag, "_busy"},  MAT_W'(bus.O_BUSY),    MAT_W'(1'b1));
      check({tag, "_rdy"},   MAT_W'(bus.O_ROW_RDY), MAT_W'(1'b0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [MAT_W-1:0] snap;
      bus.I_ROW_VLD  = 1'b0;
      bus.I_ATT_VLD  = 1'b0;
      bus.I_ROW_DATA = '0;

      // Reset state.
      repeat (2) @(negedge clk);
      check("reset_q",   bus.O_MAT_Q, '0);
      check("reset_rdy", MAT_W'(bus.O_ROW_RDY), MAT_W'(1'b0));
      rst = 1'b0;
      @(negedge clk);

      // Basic load, back-to-back beats.
      for (int b = 0; b < BEATS; b++) send_beat(0, b);
      check_start_cycle("basic");
      snap = bus.O_MAT_K;
      check("basic_k23", MAT_W'(snap[(2*D_K + 3)*D_W +: D_W]), MAT_W'(16'h0123));
      check("basic_q", bus.O_MAT_Q, pat(0, 0));
      check("basic_v", bus.O_MAT_V, pat(0, 2));

      // Long wait, matrices must hold.
      repeat (20) @(negedge clk);
      check("wait_busy", MAT_W'(bus.O_BUSY), MAT_W'(1'b1));
      check("wait_k", bus.O_MAT_K, pat(0, 1));
      finish_set(0);

      // Stall tolerance: valid pattern 1,0,0,1,...
      for (int b = 0; b < BEATS; b++) begin
         send_beat(0, b);
         if (b < BEATS - 1) idle(2);
      end
      check_start_cycle("stall");
      check("stall_q", bus.O_MAT_Q, pat(0, 0));
      check("stall_k", bus.O_MAT_K, pat(0, 1));
      check("stall_v", bus.O_MAT_V, pat(0, 2));
      finish_set(3);

      // Spurious result-valid in LOAD and in START.
      for (int b = 0; b < 5; b++) send_beat(16'h8000, b);
      @(negedge clk);
      bus.I_ROW_VLD = 1'b0;
      bus.I_ATT_VLD = 1'b1;
      @(negedge clk);
      bus.I_ATT_VLD = 1'b0;
      check("spur_load_done", MAT_W'(bus.O_DONE), MAT_W'(1'b0));
      check("spur_load_rdy",  MAT_W'(bus.O_ROW_RDY), MAT_W'(1'b1));
      for (int b = 5; b < BEATS; b++) send_beat(16'h8000, b);
      check_start_cycle("spur");
      bus.I_ATT_VLD = 1'b1;
      @(negedge clk);
      bus.I_ATT_VLD = 1'b0;
      check("spur_start_done", MAT_W'(bus.O_DONE), MAT_W'(1'b0));
      check("spur_wait_busy",  MAT_W'(bus.O_BUSY), MAT_W'(1'b1));
      check("spur_wait_start", MAT_W'(bus.O_START), MAT_W'(1'b0));
      check("spur_v", bus.O_MAT_V, pat(16'h8000, 2));
      finish_set(2);

      // Reset in the middle of a load.
      for (int b = 0; b < 7; b++) send_beat(16'h4000, b);
      @(negedge clk);
      bus.I_ROW_VLD = 1'b0;
      rst = 1'b1;
      #1;
      check("rst_mid_q", bus.O_MAT_Q, '0);
      check("rst_mid_k", bus.O_MAT_K, '0);
      @(negedge clk);
      check("rst_hold_v",   bus.O_MAT_V, '0);
      check("rst_hold_rdy", MAT_W'(bus.O_ROW_RDY), MAT_W'(1'b0));
      rst = 1'b0;
      @(negedge clk);
      send_beat(16'h2000, 0);
      @(negedge clk);
      bus.I_ROW_VLD = 1'b0;
      snap = bus.O_MAT_Q;
      check("rst_first_q00", MAT_W'(snap[D_W-1:0]), MAT_W'(16'h2000));
      check("rst_no_start",  MAT_W'(bus.O_START), MAT_W'(1'b0));
      for (int b = 1; b < BEATS; b++) send_beat(16'h2000, b);
      check_start_cycle("reload");
      check("reload_q", bus.O_MAT_Q, pat(16'h2000, 0));
      check("reload_k", bus.O_MAT_K, pat(16'h2000, 1));

      // Back-to-back: valid held high across the WAIT exit.
      repeat (2) @(negedge clk);
      bus.I_ATT_VLD  = 1'b1;
      bus.I_ROW_VLD  = 1'b1;
      bus.I_ROW_DATA = mk_row(16'h3000, 0, 0);
      @(negedge clk);
      bus.I_ATT_VLD = 1'b0;
      t_done = cyc;
      check("b2b_done", MAT_W'(bus.O_DONE),    MAT_W'(1'b1));
      check("b2b_rdy",  MAT_W'(bus.O_ROW_RDY), MAT_W'(1'b1));
      @(posedge clk);
      for (int b = 1; b < BEATS; b++) send_beat(16'h3000, b);
      check_start_cycle("b2b");
      check("b2b_gap", MAT_W'(cyc - t_done), MAT_W'(12));
      check("b2b_q", bus.O_MAT_Q, pat(16'h3000, 0));
      finish_set(1);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
